key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// key_event_ctrl
//   Turns the keycode exported by the SoC into a stream of press/release
//   events held in a small registered FIFO, and latches two joystick-style
//   control words once per video frame.
//
// Ports
//   Clk         system clock, rising edge
//   Reset       synchronous, active-high reset
//   keycode     USB HID keycode, 0x00 = no key
//   frame_tick  one-cycle pulse per video frame
//   evt_valid   FIFO head holds an event
//   evt_ready   consumer takes the head event when evt_valid is high
//   evt_data    head event, bit 8 = press(1)/release(0), bits 7:0 = keycode
//   p1_ctrl     player 1 {fire,up,down,left,right}, loaded on frame_tick
//   p2_ctrl     player 2 {fire,up,down,left,right}, loaded on frame_tick
//   overflow    sticky: an event was dropped on a full FIFO
//
// Configuration
//   KEY_EVENT_DEBOUNCE_EN  when defined, a keycode change is accepted only
//                          after it has been stable for DEBOUNCE_CYCLES.

module key_event_ctrl #(
  parameter int FIFO_DEPTH      = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [8:0] evt_data,
  output logic [4:0] p1_ctrl,
  output logic [4:0] p2_ctrl,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 in 2..16");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EMIT_REL   = 2'd1,
    EMIT_PRESS = 2'd2
  } state_e;

  state_e     state_q;
  logic [7:0] cur_key_q;
  logic [7:0] new_key_q;
  logic       change;

  // ---------------------------------------------------------------------------
  // Change detection
  // ---------------------------------------------------------------------------
`ifdef KEY_EVENT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [7:0]    prev_key_q;
  logic [CW-1:0] db_cnt_q;

  // db_cnt_q counts consecutive cycles in which keycode matched its previous
  // value; it restarts on any movement and saturates at DEBOUNCE_CYCLES.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      prev_key_q <= 8'h00;
      db_cnt_q   <= '0;
    end else begin
      prev_key_q <= keycode;
      if (keycode != prev_key_q)   db_cnt_q <= '0;
      else if (db_cnt_q != CNT_MAX) db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign change = (keycode != cur_key_q) && (keycode == prev_key_q) &&
                  (db_cnt_q == CNT_MAX);
`else
  assign change = (keycode != cur_key_q);
`endif

  // ---------------------------------------------------------------------------
  // Event sequencer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // values from the start of the cycle, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      cur_key_q <= 8'h00;
      new_key_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (change) begin
            new_key_q <= keycode;
            // A change with cur_key == 0 implies keycode != 0, so a press follows.
            state_q   <= (cur_key_q != 8'h00) ? EMIT_REL : EMIT_PRESS;
          end
        end
        EMIT_REL: begin
          if (new_key_q != 8'h00) begin
            state_q <= EMIT_PRESS;
          end else begin
            state_q   <= IDLE;
            cur_key_q <= new_key_q;
          end
        end
        EMIT_PRESS: begin
          state_q   <= IDLE;
          cur_key_q <= new_key_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic       push;
  logic [8:0] push_data;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    push      = 1'b0;
    push_data = 9'h000;
    case (state_q)
      EMIT_REL:   begin push = 1'b1; push_data = {1'b0, cur_key_q}; end
      EMIT_PRESS: begin push = 1'b1; push_data = {1'b1, new_key_q}; end
      default:    ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (registered, no fall-through)
  // ---------------------------------------------------------------------------
  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, pop, wr_en;

  assign full      = (count_q == FULL_CNT);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid && evt_ready;
  // At full, a same-cycle pop frees the slot the write lands in.
  assign wr_en     = push && (!full || pop);
  // Gate the head so an empty FIFO presents 0 even though storage is not reset.
  assign evt_data  = evt_valid ? mem[rd_ptr_q] : 9'h000;

  // NOTE: the storage array is deliberately not reset; count_q decides which
  // entries are meaningful, so clearing the array would only add reset fanout.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      // Depth is a power of 2, so pointer increments wrap naturally.
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Player control decode, latched once per frame
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] p1_decode(input logic [7:0] k);
    case (k)
      8'h2C:   return 5'b10000;  // Space: fire
      8'h1A:   return 5'b01000;  // W: up
      8'h16:   return 5'b00100;  // S: down
      8'h04:   return 5'b00010;  // A: left
      8'h07:   return 5'b00001;  // D: right
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] p2_decode(input logic [7:0] k);
    case (k)
      8'h28:   return 5'b10000;  // Enter: fire
      8'h52:   return 5'b01000;  // Up
      8'h51:   return 5'b00100;  // Down
      8'h50:   return 5'b00010;  // Left
      8'h4F:   return 5'b00001;  // Right
      default: return 5'b00000;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      p1_ctrl <= 5'b00000;
      p2_ctrl <= 5'b00000;
    end else if (frame_tick) begin
      p1_ctrl <= p1_decode(cur_key_q);
      p2_ctrl <= p2_decode(cur_key_q);
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed testbench for key_event_ctrl (FIFO_DEPTH=4, DEBOUNCE_CYCLES=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_key_event_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       frame_tick;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_data;
  logic [4:0] p1_ctrl;
  logic [4:0] p2_ctrl;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

`ifdef KEY_EVENT_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 4;
`endif

  always #5 Clk = ~Clk;

  key_event_ctrl #(
    .FIFO_DEPTH     (4),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .frame_tick(frame_tick),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .p1_ctrl   (p1_ctrl),
    .p2_ctrl   (p2_ctrl),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  // Waits (bounded) for a head event, captures it and pops it. Returns X on timeout.
  task automatic pop_evt(output logic [8:0] d);
    bit done;
    d    = 9'bx;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (evt_valid) begin
        d         = evt_data;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        done      = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    wait_ticks(2);
    Reset = 1'b0;
    tick();
    n_total++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 9'h000) $display("FAIL reset_data: got %h expected 000", evt_data); else n_pass++;
    n_total++; if (p1_ctrl !== 5'b0) $display("FAIL reset_p1: got %b expected 00000", p1_ctrl); else n_pass++;
    n_total++; if (p2_ctrl !== 5'b0) $display("FAIL reset_p2: got %b expected 00000", p2_ctrl); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
  endtask

  task automatic test_idle_to_press();
    logic [8:0] d;
    evt_ready = 1'b0;
    keycode   = 8'h1A;
`ifndef KEY_EVENT_DEBOUNCE_EN
    tick();  // change accepted, FSM moves to EMIT_PRESS
    n_total++; if (evt_valid !== 1'b0) $display("FAIL press_latency_early: got %b expected 0", evt_valid); else n_pass++;
    tick();  // event pushed
`else
    wait_ticks(SETTLE);
`endif
    n_total++; if (evt_valid !== 1'b1) $display("FAIL press_valid: got %b expected 1", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 9'h11A) $display("FAIL press_data: got %h expected 11a", evt_data); else n_pass++;
    pop_evt(d);
    wait_ticks(3);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL press_single_event: got %b expected 0", evt_valid); else n_pass++;
    n_total++; if (p1_ctrl !== 5'b00000) $display("FAIL press_p1_before_frame: got %b expected 00000", p1_ctrl); else n_pass++;
    pulse_frame();
    n_total++; if (p1_ctrl !== 5'b01000) $display("FAIL press_p1_frame: got %b expected 01000", p1_ctrl); else n_pass++;
    n_total++; if (p2_ctrl !== 5'b00000) $display("FAIL press_p2_frame: got %b expected 00000", p2_ctrl); else n_pass++;
  endtask

  task automatic test_key_swap();
    logic [8:0] d;
    keycode = 8'h50;
    wait_ticks(SETTLE + 1);
    pop_evt(d);
    n_total++; if (d !== 9'h01A) $display("FAIL swap_release: got %h expected 01a", d); else n_pass++;
    pop_evt(d);
    n_total++; if (d !== 9'h150) $display("FAIL swap_press: got %h expected 150", d); else n_pass++;
    n_total++; if (evt_valid !== 1'b0) $display("FAIL swap_empty: got %b expected 0", evt_valid); else n_pass++;
    pulse_frame();
    n_total++; if (p1_ctrl !== 5'b00000) $display("FAIL swap_p1: got %b expected 00000", p1_ctrl); else n_pass++;
    n_total++; if (p2_ctrl !== 5'b00010) $display("FAIL swap_p2: got %b expected 00010", p2_ctrl); else n_pass++;
  endtask

  task automatic test_full_fifo();
    logic [7:0] keys [6] = '{8'h00, 8'h07, 8'h00, 8'h07, 8'h00, 8'h07};
    logic [8:0] exp  [4] = '{9'h050, 9'h107, 9'h007, 9'h107};
    logic [8:0] d;
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      keycode = keys[i];
      wait_ticks(SETTLE);
    end
    n_total++; if (overflow !== 1'b1) $display("FAIL full_overflow: got %b expected 1", overflow); else n_pass++;
    n_total++; if (evt_valid !== 1'b1) $display("FAIL full_valid: got %b expected 1", evt_valid); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pop_evt(d);
      n_total++; if (d !== exp[i]) $display("FAIL full_order[%0d]: got %h expected %h", i, d, exp[i]); else n_pass++;
    end
    n_total++; if (evt_valid !== 1'b0) $display("FAIL full_count4: got valid %b expected 0 after 4 pops", evt_valid); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL full_overflow_sticky: got %b expected 1", overflow); else n_pass++;
  endtask

  task automatic test_reset_mid_emit();
    logic [8:0] d;
    keycode = 8'h00;   // cur_key is 0x07, so a release sequence starts
    tick();            // FSM now in EMIT_REL
    Reset = 1'b1;
    tick();
    n_total++; if (evt_valid !== 1'b0) $display("FAIL rst_emit_valid: got %b expected 0", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 9'h000) $display("FAIL rst_emit_data: got %h expected 000", evt_data); else n_pass++;
    n_total++; if (p1_ctrl !== 5'b0) $display("FAIL rst_emit_p1: got %b expected 00000", p1_ctrl); else n_pass++;
    n_total++; if (p2_ctrl !== 5'b0) $display("FAIL rst_emit_p2: got %b expected 00000", p2_ctrl); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_emit_overflow: got %b expected 0", overflow); else n_pass++;
    Reset = 1'b0;
    wait_ticks(SETTLE);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL rst_emit_no_push: got %b expected 0", evt_valid); else n_pass++;
    keycode = 8'h2C;
    wait_ticks(SETTLE);
    pop_evt(d);
    n_total++; if (d !== 9'h12C) $display("FAIL rst_emit_fire_press: got %h expected 12c", d); else n_pass++;
    wait_ticks(2);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL rst_emit_single: got %b expected 0", evt_valid); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    logic [8:0] exp [4] = '{9'h01A, 9'h116, 9'h016, 9'h104};
    logic [8:0] d;
    evt_ready = 1'b0;
    keycode   = 8'h1A;   // 0x02C, 0x11A
    wait_ticks(4);
    keycode   = 8'h16;   // 0x01A, 0x116 -> full
    wait_ticks(4);
    n_total++; if (evt_data !== 9'h02C) $display("FAIL pp_head_before: got %h expected 02c", evt_data); else n_pass++;
    keycode = 8'h04;
    tick();              // FSM enters EMIT_REL
    evt_ready = 1'b1;
    tick();              // push 0x016 with pop of 0x02C
    n_total++; if (evt_data !== 9'h11A) $display("FAIL pp_head_after1: got %h expected 11a", evt_data); else n_pass++;
    tick();              // push 0x104 with pop of 0x11A
    evt_ready = 1'b0;
    n_total++; if (overflow !== 1'b0) $display("FAIL pp_overflow: got %b expected 0", overflow); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      pop_evt(d);
      n_total++; if (d !== exp[i]) $display("FAIL pp_order[%0d]: got %h expected %h", i, d, exp[i]); else n_pass++;
    end
    n_total++; if (evt_valid !== 1'b0) $display("FAIL pp_count4: got valid %b expected 0 after 4 pops", evt_valid); else n_pass++;
  endtask

  task automatic test_debounce();
    Reset   = 1'b1;
    keycode = 8'h00;
    tick();
    Reset   = 1'b0;
    keycode = 8'h04;
    wait_ticks(10);
    keycode = 8'h00;
    wait_ticks(30);
    n_total++; if (evt_valid !== 1'b0) $display("FAIL db_glitch: got %b expected 0", evt_valid); else n_pass++;
    keycode = 8'h04;
    wait_ticks(30);
    n_total++; if (evt_valid !== 1'b1) $display("FAIL db_stable_valid: got %b expected 1", evt_valid); else n_pass++;
    n_total++; if (evt_data !== 9'h104) $display("FAIL db_stable_data: got %h expected 104", evt_data); else n_pass++;
  endtask

  initial begin
    Reset      = 1'b1;
    keycode    = 8'h00;
    frame_tick = 1'b0;
    evt_ready  = 1'b0;
    test_reset();
    test_idle_to_press();
    test_key_swap();
    test_full_fifo();
    test_reset_mid_emit();
`ifndef KEY_EVENT_DEBOUNCE_EN
    test_push_pop_full();
`else
    test_debounce();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
